vga_sprite_engine: RTL

VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

---
 rtl/vga_sprite_engine.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: VGA timing generator that draws one square sprite, moved by keys or bouncing off the edges.
module vga_sprite_engine #(
  parameter int COLOR_W = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int X_INIT = 296,
  parameter int Y_INIT = 216,
  parameter int SIZE_INIT = 48,
  parameter logic [3*COLOR_W-1:0] SPR_RGB = 12'hA2D,
  parameter logic [3*COLOR_W-1:0] BG_RGB = 12'hFFF
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  input  logic [3:0]         KEY,
  input  logic [9:0]         SW,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               FRAME_TICK
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int MW = HW > VW ? HW : VW;
  localparam int CW = MW > 8 ? MW : 8;
  localparam int PW = CW + 1;
  logic [1:0] sync_q;
  logic pix_en_q, run_ok, h_last, v_last, frame_end, hit;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [CW-1:0] x_q, y_q, size_q, x_d, y_d, size_d;
  logic dx_q, dy_q, dx_d, dy_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic hs_q, vs_q, blank_q, hs_d, vs_d, blank_d;
  logic signed [PW-1:0] st, x_max, y_max, x_t, y_t;
  logic x_dec, x_inc, y_dec, y_inc, x_lo, x_hi, y_lo, y_hi;
  always_comb begin
    run_ok = sync_q[1];
    h_last = h_q == HW'(H_TOTAL - 1);
    v_last = v_q == VW'(V_TOTAL - 1);
    frame_end = run_ok && pix_en_q && h_last && v_last;
    h_d = h_last ? '0 : h_q + 1'b1;
    v_d = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
    hit = PW'(h_q) >= PW'(x_q) && PW'(h_q) < PW'(x_q) + PW'(size_q) &&
          PW'(v_q) >= PW'(y_q) && PW'(v_q) < PW'(y_q) + PW'(size_q);
    blank_d = h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
    rgb_d = blank_d ? (hit ? SPR_RGB : BG_RGB) : '0;
    hs_d = !(h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_d = !(v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    size_d = CW'({SW[5:2], 3'b000}) + CW'(8);
    st = PW'({1'b0, SW[9:6]}) + PW'(1);
    // bounds come from the size loaded now, so a grown sprite is pulled back on-screen
    x_max = PW'(H_ACTIVE) - PW'(size_d);
    x_max = x_max[PW-1] ? '0 : x_max;
    y_max = PW'(V_ACTIVE) - PW'(size_d);
    y_max = y_max[PW-1] ? '0 : y_max;
    x_dec = SW[1] ? dx_q : !KEY[3] && KEY[2];
    x_inc = SW[1] ? !dx_q : KEY[3] && !KEY[2];
    y_dec = SW[1] ? dy_q : !KEY[0] && KEY[1];
    y_inc = SW[1] ? !dy_q : KEY[0] && !KEY[1];
    x_t = $signed(PW'(x_q)) + (x_dec ? -st : x_inc ? st : PW'(0));
    y_t = $signed(PW'(y_q)) + (y_dec ? -st : y_inc ? st : PW'(0));
    x_lo = x_t[PW-1] || x_t == '0;
    y_lo = y_t[PW-1] || y_t == '0;
    x_hi = x_t >= x_max;
    y_hi = y_t >= y_max;
    x_d = x_lo ? '0 : x_hi ? CW'(x_max) : CW'(x_t);
    y_d = y_lo ? '0 : y_hi ? CW'(y_max) : CW'(y_t);
    dx_d = !SW[1] ? dx_q : x_lo ? 1'b0 : x_hi ? 1'b1 : dx_q;
    dy_d = !SW[1] ? dy_q : y_lo ? 1'b0 : y_hi ? 1'b1 : dy_q;
  end
  always_ff @(posedge CLOCK_50 or negedge RST_N)
    if (!RST_N) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      pix_en_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
      x_q <= CW'(X_INIT);
      y_q <= CW'(Y_INIT);
      size_q <= CW'(SIZE_INIT);
      dx_q <= 1'b0;
      dy_q <= 1'b0;
      rgb_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      blank_q <= 1'b0;
    end else if (run_ok) begin
      pix_en_q <= !pix_en_q;
      if (pix_en_q) begin
        h_q <= h_d;
        v_q <= v_d;
        rgb_q <= rgb_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        blank_q <= blank_d;
      end
      if (frame_end && SW[0]) begin
        x_q <= x_d;
        y_q <= y_d;
        size_q <= size_d;
        dx_q <= dx_d;
        dy_q <= dy_d;
      end
    end
  end
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign FRAME_TICK = frame_end;
endmodule
